// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control unit: state-decoded datapath controls, memory wait states, decode traps.
// Outputs are combinational from state (zero-cycle); memory states stall on mem_ready low.
module mc_control_fsm #(
    parameter int OP_W        = 6,
    parameter int FUNCT_W     = 6,
    parameter int ALUCTRL_W   = 4,
    parameter bit MEM_WAIT_EN = 1'b1,
    parameter bit TRAP_EN     = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [OP_W-1:0]      Op,
    input  logic [FUNCT_W-1:0]   Funct,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 PCEn,
    output logic                 IorD,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic [1:0]           RegDst,
    output logic [1:0]           MemtoReg,
    output logic                 RegWrite,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic [1:0]           PCSrc,
    output logic                 illegal_instr,
    output logic                 instr_done,
    output logic [3:0]           state_o
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXEC_R  = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_ADDI_EX = 4'd10,
        S_ADDI_WB = 4'd11,
        S_JUMP    = 4'd12,
        S_JAL     = 4'd13,
        S_TRAP    = 4'd14
    } state_t;

    localparam logic [OP_W-1:0] OP_R    = OP_W'(6'h00);
    localparam logic [OP_W-1:0] OP_J    = OP_W'(6'h02);
    localparam logic [OP_W-1:0] OP_JAL  = OP_W'(6'h03);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'h04);
    localparam logic [OP_W-1:0] OP_BNE  = OP_W'(6'h05);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'h08);
    localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'h23);
    localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'h2B);

    localparam logic [FUNCT_W-1:0] FN_ADD = FUNCT_W'(6'h20);
    localparam logic [FUNCT_W-1:0] FN_SUB = FUNCT_W'(6'h22);
    localparam logic [FUNCT_W-1:0] FN_AND = FUNCT_W'(6'h24);
    localparam logic [FUNCT_W-1:0] FN_OR  = FUNCT_W'(6'h25);
    localparam logic [FUNCT_W-1:0] FN_NOR = FUNCT_W'(6'h27);
    localparam logic [FUNCT_W-1:0] FN_SLT = FUNCT_W'(6'h2A);

    localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(4'b0010);
    localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(4'b0110);
    localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(4'b0000);
    localparam logic [ALUCTRL_W-1:0] ALU_OR  = ALUCTRL_W'(4'b0001);
    localparam logic [ALUCTRL_W-1:0] ALU_SLT = ALUCTRL_W'(4'b0111);
    localparam logic [ALUCTRL_W-1:0] ALU_NOR = ALUCTRL_W'(4'b1100);

    state_t r_state;
    state_t w_next;
    logic   r_is_store;
    logic   r_is_bne;
    logic   w_mem_rdy;
    logic   w_pc_write;
    logic   w_beq_st;
    logic   w_bne_st;

    assign w_mem_rdy = MEM_WAIT_EN ? mem_ready : 1'b1;
    assign state_o   = r_state;

    // Op is only valid in DECODE, so the lw/sw and beq/bne choices made later are latched here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_is_store <= 1'b0;
            r_is_bne   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_is_store <= (Op == OP_SW);
                r_is_bne   <= (Op == OP_BNE);
            end
        end
    end

    always_comb begin
        w_next        = S_FETCH;
        w_pc_write    = 1'b0;
        w_beq_st      = 1'b0;
        w_bne_st      = 1'b0;
        IorD          = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        RegDst        = 2'b00;
        MemtoReg      = 2'b00;
        RegWrite      = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        ALUControl    = '0;
        PCSrc         = 2'b00;
        illegal_instr = 1'b0;
        case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                ALUSrcB    = 2'b01;
                ALUControl = ALU_ADD;
                IRWrite    = w_mem_rdy;
                w_pc_write = w_mem_rdy;
                w_next     = w_mem_rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcB    = 2'b11;
                ALUControl = ALU_ADD;
                case (Op)
                    OP_LW, OP_SW:   w_next = S_MEMADR;
                    OP_R:           w_next = S_EXEC_R;
                    OP_BEQ, OP_BNE: w_next = S_BRANCH;
                    OP_ADDI:        w_next = S_ADDI_EX;
                    OP_J:           w_next = S_JUMP;
                    OP_JAL:         w_next = S_JAL;
                    default:        w_next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = ALU_ADD;
                w_next     = r_is_store ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                IorD   = 1'b1;
                w_next = w_mem_rdy ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                MemtoReg = 2'b01;
                RegWrite = 1'b1;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                w_next   = w_mem_rdy ? S_FETCH : S_MEMWR;
            end
            S_EXEC_R: begin
                ALUSrcA = 1'b1;
                w_next  = S_ALUWB;
                case (Funct)
                    FN_ADD:  ALUControl = ALU_ADD;
                    FN_SUB:  ALUControl = ALU_SUB;
                    FN_AND:  ALUControl = ALU_AND;
                    FN_OR:   ALUControl = ALU_OR;
                    FN_NOR:  ALUControl = ALU_NOR;
                    FN_SLT:  ALUControl = ALU_SLT;
                    default: w_next     = S_TRAP;
                endcase
            end
            S_ALUWB: begin
                RegDst   = 2'b01;
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUControl = ALU_SUB;
                PCSrc      = 2'b01;
                w_beq_st   = ~r_is_bne;
                w_bne_st   = r_is_bne;
            end
            S_ADDI_EX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = ALU_ADD;
                w_next     = S_ADDI_WB;
            end
            S_ADDI_WB: RegWrite = 1'b1;
            S_JUMP: begin
                PCSrc      = 2'b10;
                w_pc_write = 1'b1;
            end
            S_JAL: begin
                PCSrc      = 2'b10;
                w_pc_write = 1'b1;
                RegWrite   = 1'b1;
                RegDst     = 2'b10;
                MemtoReg   = 2'b10;
            end
            S_TRAP: illegal_instr = TRAP_EN;
            default: w_next = S_FETCH;
        endcase
        PCEn       = w_pc_write | (w_beq_st & zero) | (w_bne_st & ~zero);
        instr_done = (w_next == S_FETCH) && (r_state != S_FETCH) && (r_state != S_IDLE);
    end

endmodule
